// File: rtl/nbit_cla_full_adder.sv
// nbit_cla_full_adder: registered N-bit carry-lookahead adder whose B operand
// passes through a DEPTH-stage shift register before reaching the adder.
// S = A + B(delayed by DEPTH) + cin, registered; used as the PC offset adder.
// Optional feature: define NBIT_CLA_OVF_EN to add a registered signed-overflow
// output (ovf). Without the macro the port and its logic do not exist.
module nbit_cla_full_adder #(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  output logic [N-1:0] S,
  output logic         cout
`ifdef NBIT_CLA_OVF_EN
  ,
  output logic         ovf
`endif
);

  // Number of 4-bit lookahead groups; the last one is partial when N % 4 != 0.
  localparam int NG = (N + 3) / 4;
  localparam int NP = 4 * NG;

  logic [N-1:0]  bd;
  logic [N-1:0]  sum;
  logic [NP-1:0] gx;
  logic [NP-1:0] px;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   grp_c;
  logic [NP:0]   c;

  // B delay line: one register per stage, each stage fed from the previous one.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [N-1:0] stage_reg;
      if (gi == 0) begin : g_head
        // Head stage captures the live B operand.
        always_ff @(posedge clk) begin
          if (reset) stage_reg <= '0;
          else       stage_reg <= B;
        end
      end else begin : g_tail
        // Later stages shift the value one step further down the line.
        always_ff @(posedge clk) begin
          if (reset) stage_reg <= '0;
          else       stage_reg <= g_stage[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign bd = g_stage[DEPTH-1].stage_reg;

  // Per-bit generate/propagate, zero-padded up to a whole number of groups so
  // the padded bits neither generate nor propagate a carry.
  always_comb begin
    gx         = '0;
    px         = '0;
    gx[N-1:0]  = A & bd;
    px[N-1:0]  = A ^ bd;
  end

  // First lookahead level: group generate and propagate as sum-of-products.
  always_comb begin
    logic term;
    term  = 1'b0;
    grp_g = '0;
    grp_p = '1;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < 4; j++) begin
        term = gx[4*k+j];
        for (int q = j + 1; q < 4; q++) term = term & px[4*k+q];
        grp_g[k] = grp_g[k] | term;
        grp_p[k] = grp_p[k] & px[4*k+j];
      end
    end
  end

  // Second lookahead level: each group carry-in is a flat function of cin and
  // the group G/P terms, so nothing ripples from group to group.
  always_comb begin
    logic carry;
    logic term;
    carry = 1'b0;
    term  = 1'b0;
    grp_c = '0;
    for (int k = 0; k <= NG; k++) begin
      carry = cin;
      for (int j = 0; j < k; j++) carry = carry & grp_p[j];
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int q = j + 1; q < k; q++) term = term & grp_p[q];
        carry = carry | term;
      end
      grp_c[k] = carry;
    end
  end

  // Bit carries inside each group, expanded from that group's carry-in.
  always_comb begin
    logic carry;
    logic term;
    carry = 1'b0;
    term  = 1'b0;
    c     = '0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < 4; j++) begin
        carry = grp_c[k];
        for (int m = 0; m < j; m++) carry = carry & px[4*k+m];
        for (int m = 0; m < j; m++) begin
          term = gx[4*k+m];
          for (int q = m + 1; q < j; q++) term = term & px[4*k+q];
          carry = carry | term;
        end
        c[4*k+j] = carry;
      end
    end
    c[NP] = grp_c[NG];
  end

  assign sum = px[N-1:0] ^ c[N-1:0];

  // Output register: result and carry-out (plus overflow when enabled).
  always_ff @(posedge clk) begin
    if (reset) begin
      S    <= '0;
      cout <= 1'b0;
`ifdef NBIT_CLA_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      S    <= sum;
      cout <= c[N];
`ifdef NBIT_CLA_OVF_EN
      ovf  <= c[N] ^ c[N-1];
`endif
    end
  end

endmodule

// File: tb/tb_nbit_cla_full_adder.sv
// Scoreboard bench for nbit_cla_full_adder (N=4, DEPTH=2). Stimulus pushes the
// expected registered result for every edge; a monitor pops and compares.
module tb_nbit_cla_full_adder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] a_in = '0;
  logic [3:0] b_drv = '0;
  logic [3:0] b_in;
  logic       cin_in = 1'b0;
  logic       fb_mode = 1'b0;
  logic [3:0] s_out;
  logic       cout_out;
`ifdef NBIT_CLA_OVF_EN
  logic       ovf_out;
`endif

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic       chk;
    logic       chk_ovf;
    logic [3:0] s;
    logic       c;
    logic       o;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign b_in = fb_mode ? s_out : b_drv;

  nbit_cla_full_adder #(.N(4), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (a_in),
    .B     (b_in),
    .cin   (cin_in),
    .S     (s_out),
    .cout  (cout_out)
`ifdef NBIT_CLA_OVF_EN
    ,
    .ovf   (ovf_out)
`endif
  );

  // Drive one cycle of inputs and queue the result expected after the edge.
  task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                      input logic ci, input logic chk, input logic [3:0] es,
                      input logic ec, input logic co, input logic eo,
                      input string nm);
    exp_t e;
    reset  = r;
    a_in   = a;
    b_drv  = b;
    cin_in = ci;
    e.chk = chk; e.chk_ovf = co; e.s = es; e.c = ec; e.o = eo; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_step(input logic r, input logic [3:0] a, input logic [3:0] b,
                          input logic ci, input logic [3:0] es, input logic ec,
                          input string nm);
    step(r, a, b, ci, 1'b1, es, ec, 1'b0, 1'b0, nm);
  endtask

  task automatic warm(input logic [3:0] a, input logic [3:0] b, input logic ci);
    step(1'b0, a, b, ci, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "warm");
  endtask

  // Monitor: after every edge, pop the oldest expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          checks++;
          if (s_out === e.s && cout_out === e.c) begin
            passes++;
            $display("ok   %s: S=%b cout=%b", e.name, s_out, cout_out);
          end else begin
            $display("FAIL %s: S=%b cout=%b, expected S=%b cout=%b",
                     e.name, s_out, cout_out, e.s, e.c);
          end
        end
`ifdef NBIT_CLA_OVF_EN
        if (e.chk_ovf) begin
          checks++;
          if (ovf_out === e.o) passes++;
          else $display("FAIL %s_ovf: ovf=%b, expected %b", e.name, ovf_out, e.o);
        end
`endif
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  logic [3:0] fb_exp_s [10];
  logic       fb_exp_c [10];

  initial begin
    logic [3:0] av, bv, sv;
    logic [4:0] tot;
    logic       ov;

    // Reset held three cycles with busy inputs, then release.
    for (int i = 0; i < 3; i++) chk_step(1'b1, 4'b0101, 4'b1111, 1'b0, 4'b0000, 1'b0, "reset_hold");
    chk_step(1'b0, 4'b0101, 4'b1111, 1'b0, 4'b0101, 1'b0, "rel_edge1");
    chk_step(1'b0, 4'b0101, 4'b1111, 1'b0, 4'b0101, 1'b0, "rel_edge2");
    chk_step(1'b0, 4'b0101, 4'b1111, 1'b0, 4'b0100, 1'b1, "rel_edge3");

    // Delay check: a single B pulse shows up exactly DEPTH+1 cycles later.
    chk_step(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "dly_reset");
    chk_step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "dly_pre");
    chk_step(1'b0, 4'b0000, 4'b0011, 1'b0, 4'b0000, 1'b0, "dly_t0");
    chk_step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "dly_t1");
    chk_step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0011, 1'b0, "dly_t2");
    chk_step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "dly_t3");

    // Wrap: 0101 + 1100 = 1_0001, with cin = 1_0010.
    chk_step(1'b0, 4'b0101, 4'b1100, 1'b0, 4'b0101, 1'b0, "wrap_fill1");
    chk_step(1'b0, 4'b0101, 4'b1100, 1'b0, 4'b0101, 1'b0, "wrap_fill2");
    chk_step(1'b0, 4'b0101, 4'b1100, 1'b0, 4'b0001, 1'b1, "wrap_c0");
    chk_step(1'b0, 4'b0101, 4'b1100, 1'b0, 4'b0001, 1'b1, "wrap_c0b");
    chk_step(1'b0, 4'b0101, 4'b1100, 1'b1, 4'b0010, 1'b1, "wrap_c1");

    // Mid-stream reset: in-flight B values must never reach S.
    chk_step(1'b0, 4'b0000, 4'b1001, 1'b0, 4'b1100, 1'b0, "mid_s1");
    chk_step(1'b0, 4'b0000, 4'b0110, 1'b0, 4'b1100, 1'b0, "mid_s2");
    chk_step(1'b0, 4'b0000, 4'b1110, 1'b0, 4'b1001, 1'b0, "mid_s3");
    chk_step(1'b1, 4'b0000, 4'b0111, 1'b0, 4'b0000, 1'b0, "mid_rst");
    for (int i = 0; i < 3; i++) chk_step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "mid_flush");

    // Feedback increment: B = S, A = 0101, steps every DEPTH+1 cycles.
    fb_exp_s = '{4'b0101, 4'b0101, 4'b0101, 4'b1010, 4'b1010,
                 4'b1010, 4'b1111, 4'b1111, 4'b1111, 4'b0100};
    fb_exp_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    fb_mode = 1'b1;
    chk_step(1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b0, "fb_reset");
    for (int i = 0; i < 10; i++)
      chk_step(1'b0, 4'b0101, 4'b0000, 1'b0, fb_exp_s[i], fb_exp_c[i], "feedback");
    fb_mode = 1'b0;

    // Carry chain corner cases with Bd = 0001.
    warm(4'b0000, 4'b0001, 1'b0);
    warm(4'b0000, 4'b0001, 1'b0);
    step(1'b0, 4'b0111, 4'b0001, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b1, "carry_0111");
    step(1'b0, 4'b1111, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, "carry_1111");

    // Exhaustive sweep against behavioural A + B + cin.
    for (int b = 0; b < 16; b++) begin
      bv = b[3:0];
      warm(4'b0000, bv, 1'b0);
      warm(4'b0000, bv, 1'b0);
      for (int a = 0; a < 16; a++) begin
        for (int ci = 0; ci < 2; ci++) begin
          av  = a[3:0];
          tot = {1'b0, av} + {1'b0, bv} + {4'b0000, ci[0]};
          sv  = tot[3:0];
          ov  = (av[3] == bv[3]) && (sv[3] != av[3]);
          step(1'b0, av, bv, ci[0], 1'b1, sv, tot[4], 1'b1, ov, "exhaustive");
        end
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(posedge clk);
      #3;
    end
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nbit_cla_full_adder.md
# nbit_cla_full_adder

Registered N-bit carry-lookahead adder with a DEPTH-stage shift-register delay line on operand B. It sums a live operand A with the value of B from DEPTH cycles earlier, then registers the result. It serves as the offset/increment datapath of the program-counter path: constant offset on A, counter value on B, sum fed back as the next counter value.

## Interface
- N, default 4: operand and sum width. Legal range 1..64.
- DEPTH, default 2: number of shift-register stages on B. Legal range 1..16.
- clk  input  1: single clock; all state updates on the rising edge.
- reset  input  1: synchronous, active-high; clears all state on the rising edge where it is sampled high.
- A  input  N: operand A; sampled directly by the adder stage, with no delay line.
- B  input  N: operand B; enters delay-line stage 0.
- cin  input  1: carry-in; sampled together with A.
- S  output  N: registered sum, (A + B_delayed + cin) mod 2^N.
- cout  output  1: registered carry-out of bit N-1.

## Operation
- Delay line:
  - Each bit of B has its own DEPTH-stage shift register. Every stage is one flip-flop.
  - On every edge with reset low, stage k is loaded from stage k-1, and stage 0 is loaded from B.
  - B_delayed is the output of stage DEPTH-1.
- Adder (combinational, between the delay line and the output register):
  - Per bit: generate g[i] = A[i] & Bd[i], propagate p[i] = A[i] ^ Bd[i].
  - Carries are computed in 4-bit lookahead groups. Each group produces group G/P, and inter-group carries come from a second lookahead level.
  - No carry may ripple across more than one group boundary.
  - The last group is partial when N is not a multiple of 4.
  - sum[i] = p[i] ^ c[i], with c[0] = cin and cout = c[N].
- Output register: S and cout load {sum, carry} on every edge with reset low.
- Arithmetic:
  - Unsigned, modulo 2^N. Overflow wraps, and cout = 1 when the unsigned result ≥ 2^N.
  - No saturation.
- Reset:
  - All delay-line stages, S and cout go to 0.
  - Reset mid-stream discards every in-flight B value. After reset deasserts, B_delayed reads 0 until DEPTH new edges have passed.
- Feedback of S into B is legal, with no combinational loop, because S is a register.

## Timing
- Latency from A/cin to S/cout: 1 cycle.
- Latency from B to S/cout: DEPTH + 1 cycles.
- S at edge t+1 = A(t) + B(t−DEPTH) + cin(t), where each term is the value sampled at that edge.
- Throughput: one result per cycle. There is no handshake and no stall.
- After reset releases at edge r:
  - S at edge r+1 = A + cin, because B_delayed = 0.
  - From edge r+DEPTH+1 onward, S reflects real B values.
- Reset is held for multiple cycles: all outputs stay 0 for the full duration.

## Configuration
- NBIT_CLA_OVF_EN defined:
  - Adds output ovf (1 bit, registered alongside S, reset value 0).
  - ovf = c[N] ^ c[N−1], the two's-complement signed overflow.
- NBIT_CLA_OVF_EN undefined:
  - Port ovf does not exist.
  - No overflow logic is synthesized.
  - All other behaviour is identical.

## Test plan
All scenarios use N=4, DEPTH=2.
- Reset: drive reset=1 for 3 cycles with A=0101, B=1111 → S=0000, cout=0 throughout. First edge after release → S=0101.
- Delay check: A=0000, cin=0, B=0011 for one cycle then 0000 → S=0011 exactly 3 edges after B was applied, and 0000 on the edges before and after.
- Wrap: A=0101, B=1100 held, cin=0 → steady state S=0001, cout=1. With cin=1 → S=0010, cout=1.
- Feedback increment: B tied to S, A=0101, cin=0, after reset.
  - S sequence from release: 0101, 0101, 0101, 1010, 1010, 1010, 1111, 1111, 1111, 0100 with cout=1.
  - The sequence steps every 3 cycles, so the bench must check the DEPTH+1 period.
- Mid-stream reset: random B stream, reset pulsed for 1 cycle → S=0 on the reset edge. Pre-reset B values never appear at S afterwards.
- Carry chain, NBIT_CLA_OVF_EN defined:
  - A=0111, Bd=0001 → S=1000, cout=0, ovf=1.
  - A=1111, Bd=0001 → S=0000, cout=1, ovf=0.
  - Exhaustive 16×16×2 compare against the behavioural A+B+cin.
